// File: rtl/rbcp_i2c_pkg.sv
// Shared constants and types for the RBCP-to-I2C command responder.
package rbcp_i2c_pkg;

  localparam logic [3:0] OFS_ID      = 4'h0;
  localparam logic [3:0] OFS_CTRL    = 4'h1;
  localparam logic [3:0] OFS_DEV     = 4'h2;
  localparam logic [3:0] OFS_REG     = 4'h3;
  localparam logic [3:0] OFS_WDATA   = 4'h4;
  localparam logic [3:0] OFS_RDATA   = 4'h5;
  localparam logic [3:0] OFS_STATUS  = 4'h6;
  localparam logic [3:0] OFS_SCRATCH = 4'h7;

  localparam int unsigned CTRL_GO = 0;
  localparam int unsigned CTRL_RW = 1;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_NACK    = 2;
  localparam int unsigned ST_OVERRUN = 3;
  localparam int unsigned ST_TIMEOUT = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} cmd_state_e;

endpackage

// File: rtl/rbcp_i2c_cmd_fsm.sv
// Command sequencer: latches the I2C command, issues a start pulse and waits for
// completion or timeout, producing one-cycle status set pulses.
module rbcp_i2c_cmd_fsm
  import rbcp_i2c_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go_i,
  input  logic       rw_i,
  input  logic [6:0] dev_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] wdata_i,
  input  logic       i2c_done_i,
  input  logic       i2c_nack_i,
  output logic       i2c_start_o,
  output logic       i2c_rw_o,
  output logic [6:0] i2c_dev_o,
  output logic [7:0] i2c_reg_o,
  output logic [7:0] i2c_wdata_o,
  output logic       busy_o,
  output logic       set_done_o,
  output logic       set_nack_o,
  output logic       set_overrun_o,
  output logic       set_timeout_o,
  output logic       rdata_load_o
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  cmd_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;
  logic            rw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q, wdata_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load          = 1'b0;
    set_done_o    = 1'b0;
    set_nack_o    = 1'b0;
    set_timeout_o = 1'b0;
    rdata_load_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Completion has priority over a timeout expiring in the same cycle.
        if (i2c_done_i) begin
          set_done_o   = 1'b1;
          set_nack_o   = i2c_nack_i;
          rdata_load_o = 1'b1;
          state_d      = IDLE;
        end else if (cnt_q == CntLast) begin
          set_timeout_o = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign set_overrun_o = go_i & busy_o;
  assign i2c_start_o   = (state_q == ISSUE);
  assign i2c_rw_o      = rw_q;
  assign i2c_dev_o     = dev_q;
  assign i2c_reg_o     = reg_q;
  assign i2c_wdata_o   = wdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        rw_q    <= rw_i;
        dev_q   <= dev_i;
        reg_q   <= reg_i;
        wdata_q <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/rbcp_i2c_responder.sv
// SiTCP RBCP local-bus responder exposing a 16-byte register window that drives
// a downstream I2C master through a start/done handshake.
module rbcp_i2c_responder
  import rbcp_i2c_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [7:0]  ID_VALUE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOC_ACT,
  input  logic [31:0] LOC_ADDR,
  input  logic [7:0]  LOC_WD,
  input  logic        LOC_WE,
  input  logic        LOC_RE,
  output logic        LOC_ACK,
  output logic [7:0]  LOC_RD,
  output logic        I2C_START,
  output logic        I2C_RW,
  output logic [6:0]  I2C_DEV,
  output logic [7:0]  I2C_REG,
  output logic [7:0]  I2C_WDATA,
  input  logic        I2C_DONE,
  input  logic        I2C_NACK,
  input  logic [7:0]  I2C_RDATA
);

  logic       hit, wr_en, rd_en, go, busy;
  logic [3:0] ofs;
  logic       ctrl_rw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q, rdata_q, scratch_q;
  logic [3:0] flags_q, flag_set, w1c;
  logic       ack_q;
  logic [7:0] rd_q, rd_mux;
  logic       set_done, set_nack, set_overrun, set_timeout, rdata_load;

  assign ofs   = LOC_ADDR[3:0];
  assign hit   = LOC_ACT & (LOC_WE | LOC_RE) & (LOC_ADDR[31:4] == BASE_ADDR[31:4]);
  assign wr_en = hit & LOC_WE;
  assign rd_en = hit & LOC_RE & ~LOC_WE;
  assign go    = wr_en & (ofs == OFS_CTRL) & LOC_WD[CTRL_GO];

  // flags_q[k] is STATUS bit k+1; a set pulse overrides a same-cycle clear.
  assign w1c      = (wr_en && ofs == OFS_STATUS) ? LOC_WD[ST_TIMEOUT:ST_DONE] : 4'b0000;
  assign flag_set = {set_timeout, set_overrun, set_nack, set_done};

  always_comb begin
    rd_mux = 8'h00;
    case (ofs)
      OFS_ID:      rd_mux = ID_VALUE;
      OFS_CTRL:    rd_mux = {6'b0, ctrl_rw_q, 1'b0};
      OFS_DEV:     rd_mux = {1'b0, dev_q};
      OFS_REG:     rd_mux = reg_q;
      OFS_WDATA:   rd_mux = wdata_q;
      OFS_RDATA:   rd_mux = rdata_q;
      OFS_STATUS:  rd_mux = {3'b0, flags_q, busy};
      OFS_SCRATCH: rd_mux = scratch_q;
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_q     <= 1'b0;
      rd_q      <= '0;
      ctrl_rw_q <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      scratch_q <= '0;
      flags_q   <= '0;
    end else begin
      ack_q   <= hit;
      flags_q <= (flags_q & ~w1c) | flag_set;
      if (rd_en) rd_q <= rd_mux;
      if (rdata_load) rdata_q <= I2C_RDATA;
      if (wr_en) begin
        case (ofs)
          OFS_CTRL:    ctrl_rw_q <= LOC_WD[CTRL_RW];
          OFS_DEV:     dev_q     <= LOC_WD[6:0];
          OFS_REG:     reg_q     <= LOC_WD;
          OFS_WDATA:   wdata_q   <= LOC_WD;
          OFS_SCRATCH: scratch_q <= LOC_WD;
          default: ;
        endcase
      end
    end
  end

  assign LOC_ACK = ack_q;
  assign LOC_RD  = rd_q;

  // The command latched on GO uses the RW bit being written in this very cycle.
  rbcp_i2c_cmd_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_cmd_fsm (
    .clk_i        (CLK),
    .rst_i        (RST),
    .go_i         (go),
    .rw_i         (LOC_WD[CTRL_RW]),
    .dev_i        (dev_q),
    .reg_i        (reg_q),
    .wdata_i      (wdata_q),
    .i2c_done_i   (I2C_DONE),
    .i2c_nack_i   (I2C_NACK),
    .i2c_start_o  (I2C_START),
    .i2c_rw_o     (I2C_RW),
    .i2c_dev_o    (I2C_DEV),
    .i2c_reg_o    (I2C_REG),
    .i2c_wdata_o  (I2C_WDATA),
    .busy_o       (busy),
    .set_done_o   (set_done),
    .set_nack_o   (set_nack),
    .set_overrun_o(set_overrun),
    .set_timeout_o(set_timeout),
    .rdata_load_o (rdata_load)
  );

endmodule
